// File: rtl/rename_history_walker_if.sv
// Dispatch/commit/recover bundle of the rename history walker.
// Squash-free signals exist only when RHB_SQUASH_FREE_EN is defined.
interface rename_history_walker_if #(
    parameter int DEPTH     = 32,
    parameter int PHYS_REGS = 64
);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int PHYS_W = $clog2(PHYS_REGS);

    logic              alloc_valid;
    logic              alloc_ready;
    logic              alloc_uses_rd;
    logic [4:0]        alloc_rd_arch;
    logic [PHYS_W-1:0] alloc_pd_old;
    logic [PHYS_W-1:0] alloc_pd_new;
    logic [IDX_W-1:0]  alloc_tag;
    logic              commit_valid;
    logic              free_valid;
    logic [PHYS_W-1:0] free_pd;
    logic              mispredict_valid;
    logic [IDX_W-1:0]  mispredict_tag;
    logic              flush_valid;
    logic              recover_valid;
    logic [4:0]        recover_rd_arch;
    logic [PHYS_W-1:0] recover_pd;
    logic              recover_busy;
    logic [IDX_W:0]    count;
`ifdef RHB_SQUASH_FREE_EN
    logic              squash_free_valid;
    logic [PHYS_W-1:0] squash_free_pd;
`endif

    modport master (
        output alloc_valid, alloc_uses_rd, alloc_rd_arch,
        output alloc_pd_old, alloc_pd_new, commit_valid,
        output mispredict_valid, mispredict_tag, flush_valid,
        input  alloc_ready, alloc_tag, free_valid, free_pd,
        input  recover_valid, recover_rd_arch, recover_pd,
`ifdef RHB_SQUASH_FREE_EN
        input  squash_free_valid, squash_free_pd,
`endif
        input  recover_busy, count
    );

    modport slave (
        input  alloc_valid, alloc_uses_rd, alloc_rd_arch,
        input  alloc_pd_old, alloc_pd_new, commit_valid,
        input  mispredict_valid, mispredict_tag, flush_valid,
        output alloc_ready, alloc_tag, free_valid, free_pd,
        output recover_valid, recover_rd_arch, recover_pd,
`ifdef RHB_SQUASH_FREE_EN
        output squash_free_valid, squash_free_pd,
`endif
        output recover_busy, count
    );
endinterface

// File: rtl/rename_history_walker.sv
// Circular rename-history buffer with youngest-first rollback walker.
// Optional: RHB_SQUASH_FREE_EN also returns squashed pd_new values.
module rename_history_walker #(
    parameter int DEPTH     = 32,
    parameter int PHYS_REGS = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    rename_history_walker_if.slave  bus
);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int PHYS_W = $clog2(PHYS_REGS);
    localparam int PTR_W  = IDX_W + 1;
    localparam logic [PTR_W-1:0] ONE = PTR_W'(1);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WALK = 1'b1;

    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [PTR_W-1:0]  r_cursor;
    logic [IDX_W-1:0]  r_tag;
    logic [0:0]        r_state;

    logic              r_uses   [DEPTH];
    logic [4:0]        r_rd     [DEPTH];
    logic [PHYS_W-1:0] r_pd_old [DEPTH];

    logic              r_free_valid;
    logic [PHYS_W-1:0] r_free_pd;
    logic              r_rec_valid;
    logic [4:0]        r_rec_rd;
    logic [PHYS_W-1:0] r_rec_pd;

    logic [PTR_W-1:0]  w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_alloc_ready;
    logic              w_alloc_fire;
    logic              w_commit_fire;
    logic [IDX_W-1:0]  w_tag_off;
    logic              w_start;
    logic [IDX_W-1:0]  w_cur;
    logic [IDX_W-1:0]  w_hidx;
    logic              w_at_tag;
    logic              w_pop;

    assign w_count = r_tail - r_head;
    assign w_empty = (r_head == r_tail);
    assign w_full  = (r_head[IDX_W-1:0] == r_tail[IDX_W-1:0])
                  && (r_head[IDX_W] != r_tail[IDX_W]);
    assign w_alloc_ready = !w_full && (r_state == S_IDLE)
                        && !bus.mispredict_valid && !bus.flush_valid;
    assign w_alloc_fire  = bus.alloc_valid && w_alloc_ready;
    assign w_commit_fire = bus.commit_valid && !w_empty && !bus.flush_valid;
    // Offset of the tag from head; live when it is below the entry count.
    assign w_tag_off = bus.mispredict_tag - r_head[IDX_W-1:0];
    assign w_start   = (r_state == S_IDLE) && bus.mispredict_valid
                    && !bus.flush_valid && ({1'b0, w_tag_off} < w_count);
    assign w_cur    = r_cursor[IDX_W-1:0];
    assign w_hidx   = r_head[IDX_W-1:0];
    assign w_at_tag = (w_cur == r_tag);
    assign w_pop    = (r_state == S_WALK) && !w_at_tag && !bus.flush_valid;

    assign bus.alloc_ready     = w_alloc_ready;
    assign bus.alloc_tag       = r_tail[IDX_W-1:0];
    assign bus.count           = w_count;
    assign bus.recover_busy    = (r_state == S_WALK);
    assign bus.free_valid      = r_free_valid;
    assign bus.free_pd         = r_free_pd;
    assign bus.recover_valid   = r_rec_valid;
    assign bus.recover_rd_arch = r_rec_rd;
    assign bus.recover_pd      = r_rec_pd;

    // Record the dispatched mapping at the tail slot.
    always_ff @(posedge clk) begin
        if (w_alloc_fire) begin
            r_uses[r_tail[IDX_W-1:0]]   <= bus.alloc_uses_rd;
            r_rd[r_tail[IDX_W-1:0]]     <= bus.alloc_rd_arch;
            r_pd_old[r_tail[IDX_W-1:0]] <= bus.alloc_pd_old;
        end
    end

    // Head advances on commit; flush empties the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
        end else if (bus.flush_valid) begin
            r_head <= '0;
        end else if (w_commit_fire) begin
            r_head <= r_head + ONE;
        end
    end

    // Tail, walk cursor and IDLE/WALK sequencing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tail   <= '0;
            r_cursor <= '0;
            r_tag    <= '0;
            r_state  <= S_IDLE;
        end else if (bus.flush_valid) begin
            r_tail  <= '0;
            r_state <= S_IDLE;
        end else if (r_state == S_IDLE) begin
            if (w_alloc_fire) begin
                r_tail <= r_tail + ONE;
            end
            if (w_start) begin
                r_cursor <= r_tail - ONE;
                r_tag    <= bus.mispredict_tag;
                r_state  <= S_WALK;
            end
        end else if (w_at_tag) begin
            r_tail  <= r_cursor + ONE;
            r_state <= S_IDLE;
        end else begin
            r_cursor <= r_cursor - ONE;
        end
    end

    // Registered free-list release and map-table restore strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_free_valid <= 1'b0;
            r_free_pd    <= '0;
            r_rec_valid  <= 1'b0;
            r_rec_rd     <= '0;
            r_rec_pd     <= '0;
        end else begin
            r_free_valid <= w_commit_fire && r_uses[w_hidx];
            r_rec_valid  <= w_pop && r_uses[w_cur];
            if (w_commit_fire && r_uses[w_hidx]) begin
                r_free_pd <= r_pd_old[w_hidx];
            end
            if (w_pop && r_uses[w_cur]) begin
                r_rec_rd <= r_rd[w_cur];
                r_rec_pd <= r_pd_old[w_cur];
            end
        end
    end

`ifdef RHB_SQUASH_FREE_EN
    logic [PHYS_W-1:0] r_pd_new [DEPTH];
    logic              r_sq_valid;
    logic [PHYS_W-1:0] r_sq_pd;

    assign bus.squash_free_valid = r_sq_valid;
    assign bus.squash_free_pd    = r_sq_pd;

    // Keep pd_new so a squashed entry can hand it back.
    always_ff @(posedge clk) begin
        if (w_alloc_fire) begin
            r_pd_new[r_tail[IDX_W-1:0]] <= bus.alloc_pd_new;
        end
    end

    // Squash-free strobe, aligned with the recover strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sq_valid <= 1'b0;
            r_sq_pd    <= '0;
        end else begin
            r_sq_valid <= w_pop && r_uses[w_cur];
            if (w_pop && r_uses[w_cur]) begin
                r_sq_pd <= r_pd_new[w_cur];
            end
        end
    end
`else
    // pd_new is only needed when squashed registers are freed here.
    logic w_unused_pd_new;
    assign w_unused_pd_new = ^bus.alloc_pd_new;
`endif
endmodule

// File: tb/tb_rename_history_walker.sv
// Directed bench for rename_history_walker.
// Squash-free checks are compiled in with RHB_SQUASH_FREE_EN.
module tb_rename_history_walker;
    localparam int DEPTH     = 32;
    localparam int PHYS_REGS = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    rename_history_walker_if #(.DEPTH(DEPTH), .PHYS_REGS(PHYS_REGS)) bus();

    rename_history_walker #(.DEPTH(DEPTH), .PHYS_REGS(PHYS_REGS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input bit uses, input int rd, input int po,
                         input int pn, input int exp_tag);
        bus.alloc_valid   = 1'b1;
        bus.alloc_uses_rd = uses;
        bus.alloc_rd_arch = 5'(rd);
        bus.alloc_pd_old  = 6'(po);
        bus.alloc_pd_new  = 6'(pn);
        #1;
        check("alloc_ready", 32'(bus.alloc_ready), 1);
        check("alloc_tag", 32'(bus.alloc_tag), 32'(exp_tag));
        tick();
        bus.alloc_valid = 1'b0;
        #1;
    endtask

    task automatic mispredict(input int tag);
        bus.mispredict_valid = 1'b1;
        bus.mispredict_tag   = 5'(tag);
        tick();
        bus.mispredict_valid = 1'b0;
        #1;
    endtask

    initial begin
        bus.alloc_valid      = 1'b0;
        bus.alloc_uses_rd    = 1'b0;
        bus.alloc_rd_arch    = '0;
        bus.alloc_pd_old     = '0;
        bus.alloc_pd_new     = '0;
        bus.commit_valid     = 1'b0;
        bus.mispredict_valid = 1'b0;
        bus.mispredict_tag   = '0;
        bus.flush_valid      = 1'b0;

        // reset state
        tick();
        tick();
        check("rst_count", 32'(bus.count), 0);
        check("rst_tag", 32'(bus.alloc_tag), 0);
        check("rst_rv", 32'(bus.recover_valid), 0);
        check("rst_busy", 32'(bus.recover_busy), 0);
        check("rst_fv", 32'(bus.free_valid), 0);
        check("rst_rpd", 32'(bus.recover_pd), 0);
        rst = 1'b0;
        #1;
        check("rst_ready", 32'(bus.alloc_ready), 1);

        // three records, then squash back to entry 0
        alloc(1, 1, 1, 32, 0);
        alloc(1, 2, 2, 33, 1);
        alloc(1, 3, 3, 34, 2);
        check("a3_count", 32'(bus.count), 3);
        check("a3_rv", 32'(bus.recover_valid), 0);
        bus.mispredict_valid = 1'b1;
        bus.mispredict_tag   = 5'd0;
        #1;
        check("mp_ready", 32'(bus.alloc_ready), 0);
        tick();
        bus.mispredict_valid = 1'b0;
        #1;
        check("w1_busy", 32'(bus.recover_busy), 1);
        check("w1_rv", 32'(bus.recover_valid), 0);
        tick();
        check("w2_busy", 32'(bus.recover_busy), 1);
        check("w2_rv", 32'(bus.recover_valid), 1);
        check("w2_rd", 32'(bus.recover_rd_arch), 3);
        check("w2_pd", 32'(bus.recover_pd), 3);
`ifdef RHB_SQUASH_FREE_EN
        check("w2_sqv", 32'(bus.squash_free_valid), 1);
        check("w2_sqpd", 32'(bus.squash_free_pd), 34);
`endif
        tick();
        check("w3_busy", 32'(bus.recover_busy), 1);
        check("w3_rv", 32'(bus.recover_valid), 1);
        check("w3_rd", 32'(bus.recover_rd_arch), 2);
        check("w3_pd", 32'(bus.recover_pd), 2);
`ifdef RHB_SQUASH_FREE_EN
        check("w3_sqv", 32'(bus.squash_free_valid), 1);
        check("w3_sqpd", 32'(bus.squash_free_pd), 33);
`endif
        tick();
        check("w4_busy", 32'(bus.recover_busy), 0);
        check("w4_rv", 32'(bus.recover_valid), 0);
        check("w4_count", 32'(bus.count), 1);
        check("w4_tag", 32'(bus.alloc_tag), 1);
        check("w4_ready", 32'(bus.alloc_ready), 1);

        // out-of-range tag is ignored
        mispredict(5);
        check("oor_busy", 32'(bus.recover_busy), 0);
        check("oor_count", 32'(bus.count), 1);

        // flush, then fill to DEPTH and wrap
        bus.flush_valid = 1'b1;
        tick();
        bus.flush_valid = 1'b0;
        #1;
        check("fl_count", 32'(bus.count), 0);
        for (int i = 0; i < DEPTH; i++) begin
            alloc(1, i, i + 1, i + 32, i);
        end
        check("full_count", 32'(bus.count), DEPTH);
        check("full_ready", 32'(bus.alloc_ready), 0);
        check("full_tag", 32'(bus.alloc_tag), 0);
        bus.commit_valid = 1'b1;
        tick();
        bus.commit_valid = 1'b0;
        #1;
        check("cm_fv", 32'(bus.free_valid), 1);
        check("cm_fpd", 32'(bus.free_pd), 1);
        check("cm_count", 32'(bus.count), DEPTH - 1);
        check("cm_ready", 32'(bus.alloc_ready), 1);
        tick();
        check("cm_fv_off", 32'(bus.free_valid), 0);
        alloc(1, 7, 7, 40, 0);
        check("wrap_count", 32'(bus.count), DEPTH);

        // commit of the tag entry during the walk
        bus.flush_valid = 1'b1;
        tick();
        bus.flush_valid = 1'b0;
        #1;
        alloc(1, 5, 10, 40, 0);
        alloc(1, 6, 11, 41, 1);
        alloc(1, 7, 12, 42, 2);
        mispredict(0);
        bus.commit_valid = 1'b1;
        #1;
        check("cw1_busy", 32'(bus.recover_busy), 1);
        tick();
        bus.commit_valid = 1'b0;
        #1;
        check("cw2_fv", 32'(bus.free_valid), 1);
        check("cw2_fpd", 32'(bus.free_pd), 10);
        check("cw2_rv", 32'(bus.recover_valid), 1);
        check("cw2_rd", 32'(bus.recover_rd_arch), 7);
        check("cw2_pd", 32'(bus.recover_pd), 12);
        tick();
        check("cw3_rd", 32'(bus.recover_rd_arch), 6);
        check("cw3_pd", 32'(bus.recover_pd), 11);
        check("cw3_busy", 32'(bus.recover_busy), 1);
        tick();
        check("cw4_busy", 32'(bus.recover_busy), 0);
        check("cw4_count", 32'(bus.count), 0);
        check("cw4_tag", 32'(bus.alloc_tag), 1);

        // flush during the walk
        alloc(1, 1, 20, 50, 1);
        alloc(1, 2, 21, 51, 2);
        alloc(1, 3, 22, 52, 3);
        alloc(1, 4, 23, 53, 4);
        mispredict(1);
        tick();
        check("fw2_rv", 32'(bus.recover_valid), 1);
        check("fw2_pd", 32'(bus.recover_pd), 23);
        bus.flush_valid = 1'b1;
        tick();
        bus.flush_valid = 1'b0;
        #1;
        check("fw3_rv", 32'(bus.recover_valid), 0);
        check("fw3_busy", 32'(bus.recover_busy), 0);
        check("fw3_count", 32'(bus.count), 0);
        check("fw3_ready", 32'(bus.alloc_ready), 1);

        // K=0 walk and entries without rd
        alloc(0, 9, 40, 60, 0);
        alloc(0, 10, 41, 61, 1);
        mispredict(1);
        check("k0_busy1", 32'(bus.recover_busy), 1);
        tick();
        check("k0_busy2", 32'(bus.recover_busy), 0);
        check("k0_rv", 32'(bus.recover_valid), 0);
        check("k0_count", 32'(bus.count), 2);
        mispredict(0);
        tick();
        check("nord_rv", 32'(bus.recover_valid), 0);
        check("nord_busy", 32'(bus.recover_busy), 1);
        tick();
        check("nord_count", 32'(bus.count), 1);
        bus.commit_valid = 1'b1;
        tick();
        bus.commit_valid = 1'b0;
        #1;
        check("nord_fv", 32'(bus.free_valid), 0);
        check("nord_c0", 32'(bus.count), 0);

        // empty commit is ignored
        bus.commit_valid = 1'b1;
        tick();
        bus.commit_valid = 1'b0;
        #1;
        check("ecm_count", 32'(bus.count), 0);

        // reset mid-walk
        alloc(1, 1, 1, 32, 1);
        alloc(1, 2, 2, 33, 2);
        alloc(1, 3, 3, 34, 3);
        mispredict(1);
        rst = 1'b1;
        #1;
        check("rw_busy", 32'(bus.recover_busy), 0);
        check("rw_count", 32'(bus.count), 0);
        tick();
        check("rw_rv", 32'(bus.recover_valid), 0);
        rst = 1'b0;
        tick();
        check("rw_rv2", 32'(bus.recover_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
